univ_shift_reg_burst: RTL and testbench

UNIV_SHIFT_REG_BURST -- requirements
Module: univ_shift_reg_burst

---
 rtl/univ_shift_reg_burst.sv | 136 +++++++++++++
 tb/tb_univ_shift_reg_burst.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg_burst.sv
// Universal N-bit shift register with single-step and counted-burst operation.
// Optional rotate modes are enabled by defining USR_ROTATE_EN.
module univ_shift_reg_burst #(
  parameter int unsigned N  = 8,
  parameter int unsigned AW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [AW-1:0] amt,
  input  logic          sin,
  input  logic [N-1:0]  pd,
  output logic [N-1:0]  q,
  output logic          sout,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {
    M_HOLD, M_SHL, M_SHR, M_LOAD, M_ROL, M_ROR, M_ASR, M_RSVD
  } mode_t;

  state_t        state_q, state_d;
  mode_t         mode_lat_q, mode_lat_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  q_q, q_d;
  logic          sout_q, sout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  mode_t mode_in, op_mode;
  logic  do_op, in_shift_class;

  assign mode_in = mode_t'(mode);

  always_comb begin
    in_shift_class = 1'b0;
    case (mode_in)
      M_SHL, M_SHR, M_ASR: in_shift_class = 1'b1;
`ifdef USR_ROTATE_EN
      M_ROL, M_ROR:        in_shift_class = 1'b1;
`endif
      default:             in_shift_class = 1'b0;
    endcase
  end

  // Sequencing: decide next state/counter and whether an operation fires this edge.
  always_comb begin
    state_d    = state_q;
    mode_lat_d = mode_lat_q;
    cnt_d      = cnt_q;
    do_op      = 1'b0;
    op_mode    = mode_in;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (in_shift_class) begin
            if (amt != '0) begin
              mode_lat_d = mode_in;
              cnt_d      = amt;
              state_d    = RUN;
            end else begin
              state_d = DONE;
            end
          end else begin
            do_op   = 1'b1;
            state_d = DONE;
          end
        end else if (en) begin
          do_op = 1'b1;
        end
      end
      RUN: begin
        do_op   = 1'b1;
        op_mode = mode_lat_q;
        cnt_d   = cnt_q - AW'(1);
        if (cnt_q <= AW'(1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    if (do_op) begin
      case (op_mode)
        M_SHL:  begin q_d = {q_q[N-2:0], sin};      sout_d = q_q[N-1]; end
        M_SHR:  begin q_d = {sin, q_q[N-1:1]};      sout_d = q_q[0];   end
        M_LOAD: begin q_d = pd; end
`ifdef USR_ROTATE_EN
        M_ROL:  begin q_d = {q_q[N-2:0], q_q[N-1]}; sout_d = q_q[N-1]; end
        M_ROR:  begin q_d = {q_q[0], q_q[N-1:1]};   sout_d = q_q[0];   end
`endif
        M_ASR:  begin q_d = {q_q[N-1], q_q[N-1:1]}; sout_d = q_q[0];   end
        default: begin q_d = q_q; end
      endcase
    end
  end

  // Status flags are registered copies of the next-state decode.
  assign busy_d = (state_d != IDLE);
  assign done_d = (state_d == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_lat_q <= M_HOLD;
      cnt_q      <= '0;
      q_q        <= '0;
      sout_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_lat_q <= mode_lat_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      sout_q     <= sout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg_burst.sv
// Self-checking bench for univ_shift_reg_burst (N=8) against a step-count model.
module tb_univ_shift_reg_burst;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, start = 1'b0, sin = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [3:0] amt = 4'd0;
  logic [7:0] pd = 8'd0;
  logic [7:0] q;
  logic       sout, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: register value, last ejected bit, remaining burst steps,
  // latched burst mode and whether the done cycle is pending.
  int m_q, m_sout, m_steps, m_lmode;
  bit m_done;

  univ_shift_reg_burst #(.N(8), .AW(4)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode), .amt(amt),
    .sin(sin), .pd(pd), .q(q), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic bit shift_class(input int md);
`ifdef USR_ROTATE_EN
    return (md == 1 || md == 2 || md == 4 || md == 5 || md == 6);
`else
    return (md == 1 || md == 2 || md == 6);
`endif
  endfunction

  function automatic void apply_op(input int md, input int s, input int p);
    int v = m_q;
    case (md)
      1: begin m_sout = v / 128; m_q = (v * 2 + s) % 256; end
      2: begin m_sout = v % 2;   m_q = v / 2 + s * 128; end
      3: m_q = p;
`ifdef USR_ROTATE_EN
      4: begin m_sout = v / 128; m_q = (v * 2) % 256 + v / 128; end
      5: begin m_sout = v % 2;   m_q = v / 2 + (v % 2) * 128; end
`endif
      6: begin m_sout = v % 2;   m_q = v / 2 + (v / 128) * 128; end
      default: ;
    endcase
  endfunction

  function automatic void model_edge();
    if (m_done) m_done = 0;
    else if (m_steps > 0) begin
      apply_op(m_lmode, int'(sin), int'(pd));
      m_steps--;
      if (m_steps == 0) m_done = 1;
    end else if (start) begin
      if (shift_class(int'(mode))) begin
        if (amt != 0) begin m_lmode = int'(mode); m_steps = int'(amt); end
        else m_done = 1;
      end else begin
        apply_op(int'(mode), int'(sin), int'(pd));
        m_done = 1;
      end
    end else if (en) apply_op(int'(mode), int'(sin), int'(pd));
  endfunction

  function automatic void model_reset();
    m_q = 0; m_sout = 0; m_steps = 0; m_lmode = 0; m_done = 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".q"},    32'(q),    32'(m_q));
    chk({tag, ".sout"}, 32'(sout), 32'(m_sout));
    chk({tag, ".busy"}, 32'(busy), 32'(m_steps > 0 || m_done));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
  endtask

  task automatic cyc(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic idle_in();
    en = 1'b0; start = 1'b0;
  endtask

  task automatic load(input logic [7:0] v);
    mode = 3'd3; pd = v; en = 1'b1; start = 1'b0;
    cyc("load");
    idle_in();
  endtask

  // Pulse start, then clock until the burst is over; returns busy-cycle count.
  task automatic burst(input string tag, input logic [2:0] md, input logic [3:0] a,
                       output int busy_cycles);
    busy_cycles = 0;
    mode = md; amt = a; start = 1'b1; en = 1'b0;
    cyc(tag);
    if (busy) busy_cycles++;
    start = 1'b0; en = 1'b1; mode = 3'd3; pd = 8'h00;
    for (int i = 0; i < 24 && busy; i++) begin
      sin = 1'($urandom_range(1));
      cyc(tag);
      if (busy) busy_cycles++;
    end
    chk({tag, ".terminated"}, 32'(busy), 32'(0));
    idle_in();
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int bc;
    int saw_done;
    model_reset();

    // Reset state
    #3;
    chk_all("reset");
    @(negedge clk);
    rst = 1'b0;
    cyc("idle");

    // Load then single-step shift left
    load(8'hA5);
    chk("load_a5", 32'(q), 32'h0A5);
    mode = 3'd1; sin = 1'b1; en = 1'b1;
    cyc("shl1");
    chk("shl1_q", 32'(q), 32'h04B);
    chk("shl1_sout", 32'(sout), 32'h1);
    idle_in();
    cyc("en0_hold");

    // ROR burst of 3 from 0x81
    load(8'h81);
    burst("ror3", 3'd5, 4'd3, bc);
`ifdef USR_ROTATE_EN
    chk("ror3_q", 32'(q), 32'h030);
    chk("ror3_busy_cycles", 32'(bc), 32'd4);
`else
    chk("ror3_q", 32'(q), 32'h081);
    chk("ror3_busy_cycles", 32'(bc), 32'd1);
`endif

    // ASR burst of 2 from 0x90
    load(8'h90);
    burst("asr2", 3'd6, 4'd2, bc);
    chk("asr2_q", 32'(q), 32'h0E4);
    chk("asr2_sout", 32'(sout), 32'h0);

    // Zero-length burst
    load(8'h3C);
    burst("shl0", 3'd1, 4'd0, bc);
    chk("shl0_q", 32'(q), 32'h03C);
    chk("shl0_busy_cycles", 32'(bc), 32'd1);

    // Burst longer than N with live sin
    load(8'h5A);
    burst("shr11", 3'd2, 4'd11, bc);
    chk("shr11_busy_cycles", 32'(bc), 32'd12);
    burst("shl15", 3'd1, 4'd15, bc);

    // Hold / reserved via start: direct done
    burst("hold_start", 3'd0, 4'd7, bc);
    chk("hold_start_busy_cycles", 32'(bc), 32'd1);
    burst("rsvd_start", 3'd7, 4'd7, bc);

    // Reset aborts a burst (ROR when rotate enabled, SHR otherwise)
    load(8'hFF);
`ifdef USR_ROTATE_EN
    mode = 3'd5;
`else
    mode = 3'd2;
`endif
    amt = 4'd5; start = 1'b1; sin = 1'b0;
    cyc("abort_accept");
    start = 1'b0;
    cyc("abort_step1");
    cyc("abort_step2");
    async_reset("abort_rst");
    chk("abort_q", 32'(q), 32'h0);
    saw_done = 0;
    for (int i = 0; i < 6; i++) begin
      cyc("abort_after");
      if (done) saw_done++;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    load(8'h6D);
    chk("post_abort_load", 32'(q), 32'h06D);

    // Rotate left single step
    load(8'h81);
    mode = 3'd4; en = 1'b1; sin = 1'b0;
    cyc("rol1");
`ifdef USR_ROTATE_EN
    chk("rol1_q", 32'(q), 32'h003);
`else
    chk("rol1_q", 32'(q), 32'h081);
`endif
    idle_in();

    // Randomized traffic, inputs also toggling while a burst runs
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(7) == 0);
      en    = 1'($urandom_range(1));
      mode  = 3'($urandom_range(7));
      amt   = 4'($urandom_range(15));
      sin   = 1'($urandom_range(1));
      pd    = 8'($urandom_range(255));
      cyc("rand");
      if ($urandom_range(79) == 0) async_reset("rand_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
